// File: rtl/dequantize_if.sv
`timescale 1ns/1ps
// dequantize_if -- serial code input and sample output bundle for dequantize.
//   Nquant    : bits per code (1..18, 0 or >18 treated as 18)
//   bitin     : serial code bit, MSB first, two's complement
//   enbitin   : bit strobe
//   sync      : code-boundary resync
//   dataout   : reconstructed signed 18-bit sample
//   endataout : one-cycle pulse marking a new dataout
//   busy      : a code is partially assembled
// master drives the code stream; slave is the dequantizer.
interface dequantize_if;
    logic [4:0]  Nquant;
    logic        bitin;
    logic        enbitin;
    logic        sync;
    logic [17:0] dataout;
    logic        endataout;
    logic        busy;

    modport master (
        output Nquant, bitin, enbitin, sync,
        input  dataout, endataout, busy
    );

    modport slave (
        input  Nquant, bitin, enbitin, sync,
        output dataout, endataout, busy
    );
endinterface

// File: rtl/dequantize.sv
`timescale 1ns/1ps
// dequantize -- assembles serial two's-complement codes of Nquant bits and
// reconstructs them as left-aligned signed 18-bit samples.
//   clock : master clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : dequantize_if.slave (Nquant, bitin, enbitin, sync in;
//           dataout, endataout, busy out)
// Optional build macro DQZ_MIDPOINT_EN: add half an output LSB to each
// sample (mid-bin reconstruction) when Nquant < 18.
module dequantize (
    input  logic        clock,
    input  logic        reset,
    dequantize_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, RECON} state_t;

    state_t      state, state_nx;
    logic [4:0]  nq, nq_nx;
    logic [4:0]  count, count_nx;
    logic [17:0] code, code_nx;
    logic [17:0] dataout_r, dataout_nx;
    logic        endataout_r, endataout_nx;
    logic [4:0]  nq_in;
    logic [17:0] recon_val;

    always_comb begin
        nq_in = (bus.Nquant == 5'd0 || bus.Nquant > 5'd18) ? 5'd18 : bus.Nquant;
    end

    // Shifting left by 18-nq drops the code bits above nq and lands the code
    // sign bit in bit 17, which is the sign-extended value scaled mod 2^18.
    always_comb begin
        recon_val = code << (5'd18 - nq);
`ifdef DQZ_MIDPOINT_EN
        if (nq < 5'd18) begin
            recon_val = recon_val + (18'd1 << (5'd17 - nq));
        end
`endif
    end

    always_comb begin
        state_nx     = state;
        nq_nx        = nq;
        count_nx     = count;
        code_nx      = code;
        dataout_nx   = dataout_r;
        endataout_nx = 1'b0;
        case (state)
            IDLE: begin
                if (bus.enbitin) begin
                    nq_nx    = nq_in;
                    code_nx  = {17'd0, bus.bitin};
                    count_nx = 5'd1;
                    state_nx = (nq_in == 5'd1) ? RECON : SHIFT;
                end
            end
            SHIFT: begin
                if (bus.sync) begin
                    code_nx  = '0;
                    count_nx = '0;
                    state_nx = IDLE;
                end else if (bus.enbitin) begin
                    code_nx  = {code[16:0], bus.bitin};
                    count_nx = count + 5'd1;
                    if (count + 5'd1 == nq) begin
                        state_nx = RECON;
                    end
                end
            end
            RECON: begin
                dataout_nx   = recon_val;
                endataout_nx = 1'b1;
                // A strobe here is bit 1 of the next code, so back-to-back
                // codes need no idle cycle; sync suppresses it.
                if (bus.enbitin && !bus.sync) begin
                    nq_nx    = nq_in;
                    code_nx  = {17'd0, bus.bitin};
                    count_nx = 5'd1;
                    state_nx = (nq_in == 5'd1) ? RECON : SHIFT;
                end else begin
                    code_nx  = '0;
                    count_nx = '0;
                    state_nx = IDLE;
                end
            end
            default: begin
                code_nx  = '0;
                count_nx = '0;
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            nq          <= 5'd18;
            count       <= '0;
            code        <= '0;
            dataout_r   <= '0;
            endataout_r <= 1'b0;
        end else begin
            state       <= state_nx;
            nq          <= nq_nx;
            count       <= count_nx;
            code        <= code_nx;
            dataout_r   <= dataout_nx;
            endataout_r <= endataout_nx;
        end
    end

    assign bus.dataout   = dataout_r;
    assign bus.endataout = endataout_r;
    assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_dequantize.sv
`timescale 1ns/1ps
// tb_dequantize -- directed and randomized checks of dequantize against a
// bit-queue reference model.
module tb_dequantize;
    logic clock;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    dequantize_if bus ();

    dequantize dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

`ifdef DQZ_MIDPOINT_EN
    localparam logic [17:0] E029  = 18'h16000;
    localparam logic [17:0] E030  = 18'h22000;
    localparam logic [17:0] E032  = 18'h00600;
    localparam logic [17:0] E033A = 18'h18000;
    localparam logic [17:0] E033B = 18'h38000;
    localparam logic [17:0] E034  = 18'h0E000;
`else
    localparam logic [17:0] E029  = 18'h14000;
    localparam logic [17:0] E030  = 18'h20000;
    localparam logic [17:0] E032  = 18'h00400;
    localparam logic [17:0] E033A = 18'h10000;
    localparam logic [17:0] E033B = 18'h30000;
    localparam logic [17:0] E034  = 18'h0C000;
`endif

    // Reference model: bits of the code in progress, its length, and a
    // completed sample waiting to appear on the next edge.
    bit          mq[$];
    int          nq_m = 18;
    bit          pending = 0;
    logic [17:0] pend_val = '0;
    logic [17:0] exp_data = '0;

    function automatic int clampq(input logic [4:0] n);
        return (n == 5'd0 || n > 5'd18) ? 18 : int'(n);
    endfunction

    task automatic model_push(input bit b);
        longint v;
        mq.push_back(b);
        if (mq.size() == nq_m) begin
            v = 0;
            foreach (mq[i]) v = v * 2 + longint'(mq[i]);
            if (mq[0]) v = v - (longint'(1) << nq_m);
            v = v * (longint'(1) << (18 - nq_m));
`ifdef DQZ_MIDPOINT_EN
            if (nq_m < 18) v = v + (longint'(1) << (17 - nq_m));
`endif
            pend_val = v[17:0];
            pending  = 1;
            mq.delete();
        end
    endtask

    task automatic model_start(input bit b, input logic [4:0] n);
        nq_m = clampq(n);
        mq.delete();
        model_push(b);
    endtask

    task automatic model_step(input bit en, input bit b, input bit s,
                              input logic [4:0] n, output bit pulse);
        pulse = 0;
        if (pending) begin
            pending  = 0;
            exp_data = pend_val;
            pulse    = 1;
            if (en && !s) model_start(b, n);
        end else if (mq.size() > 0) begin
            if (s) mq.delete();
            else if (en) model_push(b);
        end else if (en) begin
            model_start(b, n);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        pending  = 0;
        exp_data = '0;
    endtask

    task automatic check(input string tag, input logic [17:0] obs, input logic [17:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic en, input logic b, input logic s);
        bit p;
        bit bz;
        bus.enbitin = en;
        bus.bitin   = b;
        bus.sync    = s;
        model_step(en, b, s, bus.Nquant, p);
        bz = pending || (mq.size() > 0);
        @(posedge clock);
        #1;
        check("endataout", 18'(bus.endataout), 18'(p));
        check("dataout", bus.dataout, exp_data);
        check("busy", 18'(bus.busy), 18'(bz));
    endtask

    task automatic send_code(input logic [4:0] n, input logic [17:0] v);
        int len;
        bus.Nquant = n;
        len = clampq(n);
        for (int i = len - 1; i >= 0; i--) tick(1'b1, v[i], 1'b0);
    endtask

    initial begin
        reset       = 1'b0;
        bus.Nquant  = 5'd4;
        bus.bitin   = 1'b0;
        bus.enbitin = 1'b0;
        bus.sync    = 1'b0;
        #2;
        check("rst_dataout", bus.dataout, 18'h0);
        check("rst_endataout", 18'(bus.endataout), 18'h0);
        check("rst_busy", 18'(bus.busy), 18'h0);
        @(posedge clock); #1;
        reset = 1'b1;

        // Nquant=4, 0101 and 1000
        send_code(5'd4, 18'h5);
        tick(1'b0, 1'b0, 1'b0);
        check("req029", bus.dataout, E029);
        send_code(5'd4, 18'h8);
        tick(1'b0, 1'b0, 1'b0);
        check("req030", bus.dataout, E030);

        // full width, and Nquant=0 treated as 18
        send_code(5'd18, 18'h3FFFF);
        tick(1'b0, 1'b0, 1'b0);
        check("req031_18", bus.dataout, 18'h3FFFF);
        send_code(5'd0, 18'h3FFFF);
        tick(1'b0, 1'b0, 1'b0);
        check("req031_0", bus.dataout, 18'h3FFFF);

        // partial code discarded by sync
        bus.Nquant = 5'd8;
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b1);
        send_code(5'd8, 18'h01);
        tick(1'b0, 1'b0, 1'b0);
        check("req032", bus.dataout, E032);

        // back-to-back 2-bit codes, strobe every cycle
        bus.Nquant = 5'd2;
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        check("req033_a", bus.dataout, E033A);
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        check("req033_b", bus.dataout, E033B);

        // sync during reconstruction: sample still out, strobe dropped
        send_code(5'd3, 18'h3);
        tick(1'b1, 1'b1, 1'b1);
        tick(1'b0, 1'b0, 1'b0);

        // short asynchronous reset mid-code
        bus.Nquant = 5'd4;
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        #3;
        reset = 1'b0;
        #0.5;
        model_reset();
        check("req034_dataout", bus.dataout, 18'h0);
        check("req034_endataout", 18'(bus.endataout), 18'h0);
        check("req034_busy", 18'(bus.busy), 18'h0);
        #0.5;
        reset = 1'b1;
        send_code(5'd4, 18'h3);
        tick(1'b0, 1'b0, 1'b0);
        check("req034_code", bus.dataout, E034);

        // randomized stream: Nquant wanders mid-code, sparse strobes and syncs
        for (int k = 0; k < 800; k++) begin
            bus.Nquant = 5'($urandom_range(0, 31));
            tick(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 24) == 0));
        end
        // mostly short codes so many complete
        for (int k = 0; k < 800; k++) begin
            bus.Nquant = 5'($urandom_range(1, 5));
            tick(1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 39) == 0));
        end
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
